// File: rtl/soc_or1k_wb_burst_ram.sv
// Wishbone B3 slave RAM: registered classic cycles plus CTI/BTE incrementing bursts
// (linear, wrap4/8/16) served from a one-word prefetch register.
module soc_or1k_wb_burst_ram #(
  parameter int unsigned DW          = 32,
  parameter int unsigned AW          = 32,
  parameter logic [31:0] MEM_SIZE    = 32'h0200_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  localparam int unsigned   NB       = DW / 8;
  localparam int unsigned   OB       = $clog2(NB);
  localparam int unsigned   WW       = AW - OB;
  localparam int unsigned   DEPTH    = int'(MEM_SIZE) / NB;
  localparam int unsigned   IW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LIMIT    = AW'(MEM_SIZE);
  localparam logic [3:0]    WS_LAST  = 4'(WAIT_STATES - 1);
  localparam logic [2:0]    CTI_INCR = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_BURST} state_t;

  // Word-indexed so an enclosing bench can preload images by hierarchical path.
  logic [DW-1:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [WW-1:0] wadr_q, wadr_d, acc_w, nxt_w;
  logic          we_q, we_d;
  logic [1:0]    bte_q, bte_d;
  logic          ack_q, ack_d, err_q, err_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          first, wr_en, rd_en;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [DW-1:0] wr_data, rd_data;
  logic          unused_adr_bits;

  function automatic logic in_range(input logic [WW-1:0] w);
    return {w, {OB{1'b0}}} < LIMIT;
  endfunction

  function automatic logic [WW-1:0] next_word(input logic [WW-1:0] w, input logic [1:0] bte);
    logic [WW-1:0] n;
    n = w;
    case (bte)
      2'b01:   n[1:0] = w[1:0] + 2'd1;
      2'b10:   n[2:0] = w[2:0] + 3'd1;
      2'b11:   n[3:0] = w[3:0] + 4'd1;
      default: n = w + WW'(1);
    endcase
    return n;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [NB-1:0] sel);
    logic [DW-1:0] m;
    m = old;
    for (int i = 0; i < int'(NB); i++) begin
      if (sel[i]) m[i*8 +: 8] = wd[i*8 +: 8];
    end
    return m;
  endfunction

  assign unused_adr_bits = ^wb_adr_i[OB-1:0];

  // Next-state, memory access selection and registered response
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wadr_d  = wadr_q;
    we_d    = we_q;
    bte_d   = bte_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    first   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    acc_w   = wadr_q;
    nxt_w   = next_word(wadr_q, bte_q);
    wr_idx  = wadr_q[IW-1:0];
    rd_idx  = wadr_q[IW-1:0];
    case (state_q)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          wadr_d = wb_adr_i[AW-1:OB];
          we_d   = wb_we_i;
          bte_d  = wb_bte_i;
          acc_w  = wb_adr_i[AW-1:OB];
          if (WAIT_STATES == 0) begin
            state_d = S_ACK;
            first   = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == WS_LAST) begin
          state_d = S_ACK;
          first   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ACK: begin
        // First beat completes here; an incrementing burst preloads the next word.
        state_d = S_IDLE;
        if (wb_cyc_i && ack_q && wb_cti_i == CTI_INCR) begin
          state_d = S_BURST;
          wadr_d  = nxt_w;
          rd_en   = 1'b1;
          rd_idx  = nxt_w[IW-1:0];
        end
      end
      S_BURST: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (wb_stb_i) begin
          if (!in_range(wadr_q)) begin
            state_d = S_IDLE;
          end else begin
            wr_en = we_q;
            if (wb_cti_i != CTI_INCR) begin
              state_d = S_IDLE;
            end else begin
              wadr_d = nxt_w;
              rd_en  = 1'b1;
              rd_idx = nxt_w[IW-1:0];
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (first) begin
      wr_idx = acc_w[IW-1:0];
      rd_idx = acc_w[IW-1:0];
      if (in_range(acc_w)) begin
        ack_d = 1'b1;
        wr_en = we_d;
        rd_en = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    if (wb_rst_i) wr_en = 1'b0;
  end

  // Write-first: a read of the word being written this edge sees the merged data.
  assign wr_data = merge(mem[wr_idx], wb_dat_i, wb_sel_i);
  assign rd_data = (wr_en && wr_idx == rd_idx) ? wr_data : mem[rd_idx];
  assign dat_d   = rd_en ? rd_data : dat_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wadr_q  <= '0;
      we_q    <= 1'b0;
      bte_q   <= 2'b00;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wadr_q  <= wadr_d;
      we_q    <= we_d;
      bte_q   <= bte_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Burst beats are acknowledged combinationally against the held strobe.
  assign wb_ack_o = (state_q == S_BURST) ? (wb_cyc_i && wb_stb_i && in_range(wadr_q)) : ack_q;
  assign wb_err_o = (state_q == S_BURST) ? (wb_cyc_i && wb_stb_i && !in_range(wadr_q)) : err_q;
  assign wb_dat_o = dat_q;
  assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_soc_or1k_wb_burst_ram.sv
// Bench for soc_or1k_wb_burst_ram: zero- and two-wait-state instances on a shared bus,
// classic and burst scenarios checked against a queue of expected read data.
module tb_soc_or1k_wb_burst_ram;

  localparam logic [31:0] MSZ = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic        we;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        cyc0, stb0, cyc2, stb2;
  logic [31:0] dat0, dat2;
  logic        ack0, err0, rty0, ack2, err2, rty2;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] wbuf [16];

  always #5 clk = ~clk;

  soc_or1k_wb_burst_ram #(.DW(32), .AW(32), .MEM_SIZE(MSZ), .WAIT_STATES(0)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc0), .wb_stb_i(stb0), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0));

  soc_or1k_wb_burst_ram #(.DW(32), .AW(32), .MEM_SIZE(MSZ), .WAIT_STATES(2)) dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc2), .wb_stb_i(stb2), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat2), .wb_ack_o(ack2), .wb_err_o(err2), .wb_rty_o(rty2));

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic set_bus(input logic which, input logic on);
    if (which) begin cyc2 = on; stb2 = on; end
    else begin cyc0 = on; stb0 = on; end
  endtask

  // Classic single transfer; lat = clock edges from the sampling edge to the response.
  task automatic xfer(input logic which, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic w, output logic [31:0] rd,
                      output logic ak, output logic er, output logic ak_after, output int lat);
    @(posedge clk); #1;
    adr = a; wdat = d; sel = s; we = w; cti = 3'b000; bte = 2'b00;
    set_bus(which, 1'b1);
    lat = -1; rd = '0; ak = 1'b0; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (which ? (ack2 || err2) : (ack0 || err0)) begin lat = i; break; end
    end
    rd = which ? dat2 : dat0;
    ak = which ? ack2 : ack0;
    er = which ? err2 : err0;
    @(posedge clk); #1;
    set_bus(which, 1'b0); we = 1'b0;
    @(negedge clk);
    ak_after = which ? (ack2 || err2) : (ack0 || err0);
  endtask

  // Incrementing burst on the zero-wait instance; read data of acked beats goes to got_q.
  task automatic burst(input logic [31:0] a, input logic w, input logic [1:0] b, input int n,
                       output int acks, output int errs, output int cycles, output logic ak_after);
    int   idx;
    logic got, bad;
    got_q.delete(); acks = 0; errs = 0; cycles = 0; idx = 0;
    @(posedge clk); #1;
    adr = a; we = w; bte = b; sel = 4'hF; wdat = wbuf[0];
    cti = (n == 1) ? 3'b111 : 3'b010;
    cyc0 = 1'b1; stb0 = 1'b1;
    while (idx < n && cycles < 40) begin
      @(negedge clk); cycles++;
      got = ack0; bad = err0;
      if (got) begin got_q.push_back(dat0); acks++; end
      if (bad) errs++;
      @(posedge clk); #1;
      if (bad) break;
      if (got) begin
        idx++;
        if (idx < n) begin
          wdat = wbuf[idx];
          cti  = (idx == n - 1) ? 3'b111 : 3'b010;
        end
      end
    end
    cyc0 = 1'b0; stb0 = 1'b0; we = 1'b0; cti = 3'b000;
    @(negedge clk);
    ak_after = ack0 || err0;
  endtask

  task automatic test_reset;
    rst = 1'b1; adr = '0; wdat = '0; sel = '0; we = 1'b0; cti = '0; bte = '0;
    cyc0 = 1'b0; stb0 = 1'b0; cyc2 = 1'b0; stb2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL reset_ack0 got=%b exp=0", ack0); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL reset_err0 got=%b exp=0", err0); end
    checks++; if (dat0 !== 32'h0) begin failures++; $display("FAIL reset_dat0 got=%h exp=0", dat0); end
    checks++; if (rty0 !== 1'b0) begin failures++; $display("FAIL reset_rty0 got=%b exp=0", rty0); end
    checks++; if (ack2 !== 1'b0) begin failures++; $display("FAIL reset_ack2 got=%b exp=0", ack2); end
    checks++; if (err2 !== 1'b0) begin failures++; $display("FAIL reset_err2 got=%b exp=0", err2); end
    checks++; if (rty2 !== 1'b0) begin failures++; $display("FAIL reset_rty2 got=%b exp=0", rty2); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_classic;
    logic [31:0] rd; logic ak, er, aa; int lat;
    xfer(1'b0, 32'h100, 32'hDEADBEEF, 4'hF, 1'b1, rd, ak, er, aa, lat);
    checks++; if (ak !== 1'b1) begin failures++; $display("FAIL classic_wr_ack got=%b exp=1", ak); end
    checks++; if (lat != 1) begin failures++; $display("FAIL classic_wr_lat got=%0d exp=1", lat); end
    exp_q.push_back(32'hDEADBEEF);
    xfer(1'b0, 32'h100, 32'h0, 4'hF, 1'b0, rd, ak, er, aa, lat);
    checks++; if (ak !== 1'b1 || er !== 1'b0) begin failures++; $display("FAIL classic_rd_ack got=%b/%b exp=1/0", ak, er); end
    checks++; if (lat != 1) begin failures++; $display("FAIL classic_rd_lat got=%0d exp=1", lat); end
    checks++; if (rd !== exp_q[0]) begin failures++; $display("FAIL classic_rd_data got=%h exp=%h", rd, exp_q[0]); end
    void'(exp_q.pop_front());
    checks++; if (aa !== 1'b0) begin failures++; $display("FAIL classic_ack_pulse got=%b exp=0", aa); end
  endtask

  task automatic test_wait_states;
    logic [31:0] rd; logic ak, er, aa; int lat;
    xfer(1'b1, 32'h0, 32'h0, 4'hF, 1'b0, rd, ak, er, aa, lat);
    checks++; if (ak !== 1'b1) begin failures++; $display("FAIL ws2_ack got=%b exp=1", ak); end
    checks++; if (lat != 3) begin failures++; $display("FAIL ws2_lat got=%0d exp=3", lat); end
    checks++; if (aa !== 1'b0) begin failures++; $display("FAIL ws2_ack_pulse got=%b exp=0", aa); end
    xfer(1'b1, 32'h4, 32'hCAFEF00D, 4'hF, 1'b1, rd, ak, er, aa, lat);
    exp_q.push_back(32'hCAFEF00D);
    xfer(1'b1, 32'h4, 32'h0, 4'hF, 1'b0, rd, ak, er, aa, lat);
    checks++; if (rd !== exp_q[0]) begin failures++; $display("FAIL ws2_data got=%h exp=%h", rd, exp_q[0]); end
    void'(exp_q.pop_front());
    checks++; if (lat != 3) begin failures++; $display("FAIL ws2_rd_lat got=%0d exp=3", lat); end
  endtask

  task automatic test_burst_linear;
    logic [31:0] rd; logic ak, er, aa; int lat, acks, errs, cyc;
    for (int i = 0; i < 4; i++) xfer(1'b0, 32'h100 + 32'(4 * i), 32'(i + 1), 4'hF, 1'b1, rd, ak, er, aa, lat);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i + 1));
    burst(32'h100, 1'b0, 2'b00, 4, acks, errs, cyc, aa);
    checks++; if (acks != 4 || errs != 0) begin failures++; $display("FAIL lin_acks got=%0d/%0d exp=4/0", acks, errs); end
    checks++; if (cyc != 5) begin failures++; $display("FAIL lin_back_to_back got=%0d exp=5", cyc); end
    checks++; if (aa !== 1'b0) begin failures++; $display("FAIL lin_idle_after got=%b exp=0", aa); end
    while (exp_q.size() > 0) begin
      logic [31:0] e, g;
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hXXXX_XXXX;
      checks++; if (g !== e) begin failures++; $display("FAIL lin_data got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_burst_wrap4;
    logic [31:0] rd; logic ak, er, aa; int lat, acks, errs, cyc;
    logic [31:0] a;
    wbuf[0] = 32'hAAAA_0001; wbuf[1] = 32'hBBBB_0002; wbuf[2] = 32'hCCCC_0003; wbuf[3] = 32'hDDDD_0004;
    burst(32'h108, 1'b1, 2'b01, 4, acks, errs, cyc, aa);
    checks++; if (acks != 4) begin failures++; $display("FAIL wrap4_acks got=%0d exp=4", acks); end
    exp_q.push_back(wbuf[0]); exp_q.push_back(wbuf[1]); exp_q.push_back(wbuf[2]); exp_q.push_back(wbuf[3]);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      a = 32'h100 + 32'(((i + 2) % 4) * 4);
      xfer(1'b0, a, 32'h0, 4'hF, 1'b0, rd, ak, er, aa, lat);
      e = exp_q.pop_front();
      checks++; if (rd !== e) begin failures++; $display("FAIL wrap4_word_%h got=%h exp=%h", a, rd, e); end
    end
  endtask

  task automatic test_sel_and_range;
    logic [31:0] rd; logic ak, er, aa; int lat;
    xfer(1'b0, 32'h200, 32'h11223344, 4'hF, 1'b1, rd, ak, er, aa, lat);
    xfer(1'b0, 32'h200, 32'h0000AA00, 4'b0010, 1'b1, rd, ak, er, aa, lat);
    exp_q.push_back(32'h1122AA44);
    xfer(1'b0, 32'h200, 32'h0, 4'hF, 1'b0, rd, ak, er, aa, lat);
    checks++; if (rd !== exp_q[0]) begin failures++; $display("FAIL sel_merge got=%h exp=%h", rd, exp_q[0]); end
    void'(exp_q.pop_front());
    xfer(1'b0, MSZ, 32'h0, 4'hF, 1'b0, rd, ak, er, aa, lat);
    checks++; if (er !== 1'b1 || ak !== 1'b0) begin failures++; $display("FAIL range_err got=err%b ack%b exp=err1 ack0", er, ak); end
    checks++; if (lat != 1) begin failures++; $display("FAIL range_lat got=%0d exp=1", lat); end
    xfer(1'b0, MSZ - 32'h4, 32'h0, 4'hF, 1'b0, rd, ak, er, aa, lat);
    checks++; if (er !== 1'b0 || ak !== 1'b1) begin failures++; $display("FAIL range_last got=err%b ack%b exp=err0 ack1", er, ak); end
  endtask

  task automatic test_burst_cross;
    int acks, errs, cyc; logic aa;
    burst(MSZ - 32'h8, 1'b0, 2'b00, 4, acks, errs, cyc, aa);
    checks++; if (acks != 2 || errs != 1) begin failures++; $display("FAIL cross_end got=%0d/%0d exp=2/1", acks, errs); end
    checks++; if (aa !== 1'b0) begin failures++; $display("FAIL cross_idle got=%b exp=0", aa); end
  endtask

  task automatic test_reset_mid_burst;
    logic [31:0] rd; logic ak, er, aa; int lat;
    for (int i = 0; i < 4; i++) xfer(1'b0, 32'h300 + 32'(4 * i), 32'h5500_0001 + 32'(i), 4'hF, 1'b1, rd, ak, er, aa, lat);
    @(posedge clk); #1;
    adr = 32'h300; we = 1'b1; bte = 2'b00; sel = 4'hF; wdat = 32'h7700_0001; cti = 3'b010;
    cyc0 = 1'b1; stb0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack0) break;
    end
    checks++; if (ack0 !== 1'b1) begin failures++; $display("FAIL rstb_beat1 got=%b exp=1", ack0); end
    @(posedge clk); #1; wdat = 32'h7700_0002;
    @(negedge clk);
    checks++; if (ack0 !== 1'b1) begin failures++; $display("FAIL rstb_beat2 got=%b exp=1", ack0); end
    #1 rst = 1'b1;
    #1;
    checks++; if (ack0 !== 1'b0 || err0 !== 1'b0) begin failures++; $display("FAIL rstb_async got=ack%b err%b exp=0/0", ack0, err0); end
    checks++; if (dat0 !== 32'h0) begin failures++; $display("FAIL rstb_dat got=%h exp=0", dat0); end
    @(posedge clk); #1;
    cyc0 = 1'b0; stb0 = 1'b0; we = 1'b0; cti = 3'b000;
    @(posedge clk); #1; rst = 1'b0;
    exp_q.push_back(32'h7700_0001); exp_q.push_back(32'h5500_0003); exp_q.push_back(32'h5500_0004);
    xfer(1'b0, 32'h300, 32'h0, 4'hF, 1'b0, rd, ak, er, aa, lat);
    checks++; if (rd !== exp_q[0]) begin failures++; $display("FAIL rstb_w0 got=%h exp=%h", rd, exp_q[0]); end
    void'(exp_q.pop_front());
    xfer(1'b0, 32'h308, 32'h0, 4'hF, 1'b0, rd, ak, er, aa, lat);
    checks++; if (rd !== exp_q[0]) begin failures++; $display("FAIL rstb_w2 got=%h exp=%h", rd, exp_q[0]); end
    void'(exp_q.pop_front());
    xfer(1'b0, 32'h30C, 32'h0, 4'hF, 1'b0, rd, ak, er, aa, lat);
    checks++; if (rd !== exp_q[0]) begin failures++; $display("FAIL rstb_w3 got=%h exp=%h", rd, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_classic();
    test_wait_states();
    test_burst_linear();
    test_burst_wrap4();
    test_sel_and_range();
    test_burst_cross();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
